// File: rtl/md_bus_writer.sv
// CADR MD/bus write initiator: one active + one pending write, four-phase req/ack to the bus interface.
// Optional REQ timeout guarded by `MD_BUS_WRITER_TIMEOUT_EN (undefined: wait for ack forever).
module md_bus_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [21:0] vma,
  input  logic [31:0] md,
  output logic        ready,
  output logic        busy,
  output logic        busint_req,
  output logic        busint_write,
  output logic [21:0] busint_addr,
  output logic [31:0] busint_bus_out,
  input  logic        busint_ack,
  output logic        done,
  output logic        overrun,
  output logic        err_timeout,
  input  logic        clr_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("md_bus_writer: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKWAIT} state_t;

  state_t      r_state;
  logic        r_req;
  logic [21:0] r_addr;
  logic [31:0] r_data;
  logic [21:0] r_pend_addr;
  logic [31:0] r_pend_data;
  logic        r_pend_valid;
  logic        r_done;
  logic        r_overrun;

  logic        w_accept;
  logic        w_timeout;
  logic        w_finish;

`ifdef MD_BUS_WRITER_TIMEOUT_EN
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_cnt;
  logic       r_err_timeout;
  assign w_timeout   = (r_state == S_REQ) && !busint_ack && (r_cnt == LP_LAST);
  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign w_accept = start && !r_pend_valid;
  // A pending entry left in IDLE (start coincided with a no-pending completion) is promoted next cycle.
  assign w_finish = ((r_state == S_ACKWAIT) && !busint_ack) || w_timeout ||
                    ((r_state == S_IDLE) && r_pend_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef MD_BUS_WRITER_TIMEOUT_EN
      r_cnt         <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      if (start && r_pend_valid) r_overrun <= 1'b1;
      else if (clr_err)          r_overrun <= 1'b0;

`ifdef MD_BUS_WRITER_TIMEOUT_EN
      if (w_timeout)    r_err_timeout <= 1'b1;
      else if (clr_err) r_err_timeout <= 1'b0;
`endif

      if (w_accept && (r_state != S_IDLE)) begin
        r_pend_addr  <= vma;
        r_pend_data  <= md;
        r_pend_valid <= 1'b1;
      end

      if (w_finish) begin
        if (r_state == S_ACKWAIT) r_done <= 1'b1;
        if (r_pend_valid) begin
          r_addr       <= r_pend_addr;
          r_data       <= r_pend_data;
          r_pend_valid <= 1'b0;
          r_req        <= 1'b1;
          r_state      <= S_REQ;
`ifdef MD_BUS_WRITER_TIMEOUT_EN
          r_cnt        <= '0;
`endif
        end else begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_addr  <= vma;
              r_data  <= md;
              r_req   <= 1'b1;
              r_state <= S_REQ;
`ifdef MD_BUS_WRITER_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end
          end
          S_REQ: begin
            if (busint_ack) begin
              r_req   <= 1'b0;
              r_state <= S_ACKWAIT;
            end else begin
`ifdef MD_BUS_WRITER_TIMEOUT_EN
              r_cnt <= r_cnt + 8'd1;
`endif
            end
          end
          S_ACKWAIT: begin
          end
          default: begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ready          = !r_pend_valid;
  assign busy           = (r_state != S_IDLE);
  assign busint_req     = r_req;
  assign busint_write   = r_req;
  assign busint_addr    = r_addr;
  assign busint_bus_out = r_data;
  assign done           = r_done;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_md_bus_writer.sv
// Directed bench for md_bus_writer: single write, posted pair, overrun, start/completion overlap,
// reset mid-transfer, and the timeout / no-timeout behaviour selected by MD_BUS_WRITER_TIMEOUT_EN.
module tb_md_bus_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [21:0] vma;
  logic [31:0] md;
  logic        ready;
  logic        busy;
  logic        busint_req;
  logic        busint_write;
  logic [21:0] busint_addr;
  logic [31:0] busint_bus_out;
  logic        busint_ack;
  logic        done;
  logic        overrun;
  logic        err_timeout;
  logic        clr_err;

  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned n_done = 0;

  always #5 clk = ~clk;

  md_bus_writer #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .vma            (vma),
    .md             (md),
    .ready          (ready),
    .busy           (busy),
    .busint_req     (busint_req),
    .busint_write   (busint_write),
    .busint_addr    (busint_addr),
    .busint_bus_out (busint_bus_out),
    .busint_ack     (busint_ack),
    .done           (done),
    .overrun        (overrun),
    .err_timeout    (err_timeout),
    .clr_err        (clr_err)
  );

  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [21:0] a, input logic [31:0] d);
    start = 1'b1; vma = a; md = d;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; vma = '0; md = '0; busint_ack = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req", busint_req, 1'b0);
    chk1("rst_write", busint_write, 1'b0);
    chkw("rst_addr", 32'(busint_addr), 32'h0);
    chkw("rst_data", busint_bus_out, 32'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    chk1("rst_tmo", err_timeout, 1'b0);
    reset_n = 1'b1;
    tick();

    // Single write
    issue(22'h001234, 32'hDEADBEEF);
    tick(); start = 1'b0;
    chk1("sw_req", busint_req, 1'b1);
    chk1("sw_write", busint_write, 1'b1);
    chkw("sw_addr", 32'(busint_addr), 32'h001234);
    chkw("sw_data", busint_bus_out, 32'hDEADBEEF);
    chk1("sw_busy", busy, 1'b1);
    tick();
    chk1("sw_req_hold", busint_req, 1'b1);
    busint_ack = 1'b1;
    tick();
    chk1("sw_req_rel", busint_req, 1'b0);
    chk1("sw_nodone", done, 1'b0);
    busint_ack = 1'b0;
    tick();
    chk1("sw_done", done, 1'b1);
    chk1("sw_idle", busy, 1'b0);
    tick();
    chk1("sw_done_pulse", done, 1'b0);
    chkw("sw_ndone", 32'(n_done), 32'd1);

    // Posted pair
    issue(22'h0000A1, 32'h11111111);
    tick(); start = 1'b0;
    chkw("pp_addrA", 32'(busint_addr), 32'h0000A1);
    tick();
    issue(22'h0000B2, 32'h22222222);
    tick(); start = 1'b0;
    chk1("pp_ready0", ready, 1'b0);
    chkw("pp_addrA_hold", 32'(busint_addr), 32'h0000A1);
    busint_ack = 1'b1;
    tick();
    chk1("pp_relA", busint_req, 1'b0);
    busint_ack = 1'b0;
    tick();
    chk1("pp_doneA", done, 1'b1);
    chk1("pp_reqB", busint_req, 1'b1);
    chkw("pp_addrB", 32'(busint_addr), 32'h0000B2);
    chkw("pp_dataB", busint_bus_out, 32'h22222222);
    chk1("pp_ready1", ready, 1'b1);
    busint_ack = 1'b1;
    tick();
    busint_ack = 1'b0;
    tick();
    chk1("pp_doneB", done, 1'b1);
    chk1("pp_idle", busy, 1'b0);
    tick();
    chkw("pp_ndone", 32'(n_done), 32'd3);

    // Overrun: active C, pending D, E dropped; F with clr_err shows set winning
    issue(22'h0000C1, 32'h33333333);
    tick();
    issue(22'h0000D1, 32'h44444444);
    tick();
    issue(22'h0000E1, 32'h55555555);
    tick(); start = 1'b0;
    chk1("ov_set", overrun, 1'b1);
    chk1("ov_ready", ready, 1'b0);
    issue(22'h0000F1, 32'h66666666); clr_err = 1'b1;
    tick(); start = 1'b0; clr_err = 1'b0;
    chk1("ov_set_wins", overrun, 1'b1);
    busint_ack = 1'b1;
    tick();
    busint_ack = 1'b0;
    tick();
    chkw("ov_addrD", 32'(busint_addr), 32'h0000D1);
    busint_ack = 1'b1;
    tick();
    busint_ack = 1'b0;
    tick();
    chk1("ov_idle", busy, 1'b0);
    chkw("ov_addr_notE", 32'(busint_addr), 32'h0000D1);
    chk1("ov_sticky", overrun, 1'b1);
    clr_err = 1'b1;
    tick(); clr_err = 1'b0;
    chk1("ov_clr", overrun, 1'b0);
    tick();
    chkw("ov_ndone", 32'(n_done), 32'd5);

    // Start in the same cycle as a no-pending completion
    issue(22'h000123, 32'h77777777);
    tick(); start = 1'b0;
    busint_ack = 1'b1;
    tick();
    busint_ack = 1'b0;
    issue(22'h000456, 32'h88888888);
    tick(); start = 1'b0;
    chk1("sc_done", done, 1'b1);
    chk1("sc_ready0", ready, 1'b0);
    tick();
    chk1("sc_req", busint_req, 1'b1);
    chkw("sc_addr", 32'(busint_addr), 32'h000456);
    chkw("sc_data", busint_bus_out, 32'h88888888);
    chk1("sc_ready1", ready, 1'b1);
    busint_ack = 1'b1;
    tick();
    busint_ack = 1'b0;
    tick();
    chk1("sc_done2", done, 1'b1);
    tick();
    chkw("sc_ndone", 32'(n_done), 32'd7);

    // Reset in ACKWAIT with pending valid
    issue(22'h000AAA, 32'h99999999);
    tick();
    issue(22'h000BBB, 32'hAAAAAAAA);
    tick(); start = 1'b0;
    busint_ack = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk1("mr_req", busint_req, 1'b0);
    chk1("mr_busy", busy, 1'b0);
    chk1("mr_ready", ready, 1'b1);
    chkw("mr_addr", 32'(busint_addr), 32'h0);
    busint_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk1("mr_req_after", busint_req, 1'b0);
    chkw("mr_ndone", 32'(n_done), 32'd7);

`ifdef MD_BUS_WRITER_TIMEOUT_EN
    // Timeout with TIMEOUT_CYCLES=4: req high for exactly 4 cycles
    issue(22'h000777, 32'hBBBBBBBB);
    tick(); start = 1'b0;
    chk1("to_req1", busint_req, 1'b1);
    tick(); chk1("to_req2", busint_req, 1'b1);
    tick(); chk1("to_req3", busint_req, 1'b1);
    tick(); chk1("to_req4", busint_req, 1'b1);
    chk1("to_noerr_yet", err_timeout, 1'b0);
    tick();
    chk1("to_req_drop", busint_req, 1'b0);
    chk1("to_err", err_timeout, 1'b1);
    chk1("to_idle", busy, 1'b0);
    chk1("to_nodone", done, 1'b0);
    clr_err = 1'b1;
    tick(); clr_err = 1'b0;
    chk1("to_clr", err_timeout, 1'b0);
    chkw("to_ndone", 32'(n_done), 32'd7);
`else
    // No timeout logic: ack withheld for 1000 cycles
    issue(22'h000777, 32'hBBBBBBBB);
    tick(); start = 1'b0;
    repeat (1000) tick();
    chk1("nt_req", busint_req, 1'b1);
    chk1("nt_err", err_timeout, 1'b0);
    chkw("nt_addr", 32'(busint_addr), 32'h000777);
    busint_ack = 1'b1;
    tick();
    busint_ack = 1'b0;
    tick();
    chk1("nt_done", done, 1'b1);
    chk1("nt_idle", busy, 1'b0);
    tick();
    chkw("nt_ndone", 32'(n_done), 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_bus_writer.md
# md_bus_writer

Memory write initiator for the CADR memory path. It is the transmit side of the MD/bus-interface datapath. It captures a write request (VMA address plus MD data) from the processor and runs a four-phase req/ack handshake with the bus interface to deliver the word. It holds one active and one pending request, so a second write can be posted while the first is still on the bus. Completion and timeout status are reported back to the memory control logic.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of REQ cycles without ack before the transfer is abandoned (8-bit counter; legal range 1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  write request strobe, sampled each cycle.
- vma  in  22  write address, sampled with start.
- md  in  32  write data, sampled with start.
- ready  out  1  pending slot empty; start is accepted only when ready=1.
- busy  out  1  a transfer is active (state != IDLE).
- busint_req  out  1  bus request, four-phase.
- busint_write  out  1  equals busint_req; marks the cycle as a write.
- busint_addr  out  22  address of the active transfer.
- busint_bus_out  out  32  data of the active transfer.
- busint_ack  in  1  bus acknowledge.
- done  out  1  one-cycle pulse per completed transfer.
- overrun  out  1  sticky; set by start while ready=0.
- err_timeout  out  1  sticky; set by an abandoned transfer.
- clr_err  in  1  clears overrun and err_timeout.

## Operation
- States: IDLE, REQ, ACKWAIT (ack seen, waiting for ack to fall).
- Registers:
  - active slot: addr, data.
  - pending slot: addr, data, valid.
- start with ready=1:
  - In IDLE with no pending entry, the request loads the active slot and the state goes to REQ.
  - Otherwise the request loads the pending slot and sets pending valid.
- start with ready=0: the request is dropped, overrun is set, and no other state changes.
- REQ: busint_req=1 and busint_addr/bus_out are held stable. When busint_ack=1, go to ACKWAIT.
- ACKWAIT: busint_req=0. When busint_ack=0:
  - done is pulsed.
  - If pending is valid, pending is promoted to the active slot, pending valid clears, and the state goes to REQ.
  - Otherwise the state goes to IDLE.
- Timeout counter:
  - Cleared on entry to REQ and incremented each REQ cycle with ack=0.
  - When the count reaches TIMEOUT_CYCLES: err_timeout is set, req drops, no done is pulsed, and the state advances as for ack-fall (promote pending or go to IDLE).
- Simultaneous start and completion in the same cycle: promotion uses the old pending slot. The new start is judged against the pre-edge ready value.
- Simultaneous clr_err and a new error in the same cycle: set wins.
- ready = !pending_valid. busy = (state != IDLE).

## Timing
- Reset values: state IDLE, busint_req=0, busint_write=0, busint_addr=0, busint_bus_out=0, done=0, overrun=0, err_timeout=0, pending valid=0. Therefore ready=1 and busy=0.
- Reset asserted mid-transfer: req drops asynchronously, and both slots are discarded with no done.
- Start to request: start in IDLE at edge N gives busint_req=1 after edge N (one-cycle latency).
- Request release: ack=1 sampled at edge K gives req=0 after K.
- Completion: ack=0 sampled at edge M gives done=1 for the cycle after M. A pending transfer has req=1 in that same cycle.
- Minimum transfer: 3 cycles, from req rise to done, with a single-cycle ack.
- All outputs are registered. There is no combinational path from busint_ack to any output.

## Configuration
- MD_BUS_WRITER_TIMEOUT_EN defined:
  - The timeout counter and err_timeout behave as above.
- Undefined:
  - The counter is not built.
  - REQ waits for ack indefinitely.
  - err_timeout is tied to 0, and clr_err clears only overrun.

## Test plan
- Single write: start with vma=22'h001234 and md=32'hDEADBEEF. Expected: req high 1 cycle later with addr/data matching; ack held 1 cycle gives req low; ack low gives one done pulse; then busy=0.
- Posted pair:
  - start A, then start B 2 cycles later. Expected: ready=0 after B.
  - On A's done, req is high in the same cycle with B's addr/data and ready returns to 1.
  - Exactly 2 done pulses in total.
- Overrun: with active and pending both full, a third start. Expected: overrun=1; the third address never appears on busint_addr. After clr_err, overrun=0.
- Timeout (macro on, TIMEOUT_CYCLES=4): ack never asserted. Expected: req high for exactly 4 cycles, then err_timeout=1, busy=0, and no done pulse.
- Reset mid-transfer: reset_n low while in ACKWAIT with pending valid. Expected: all outputs at reset values immediately; no later done after release.
- Macro off: ack withheld for 1000 cycles. Expected: req stays high and err_timeout stays 0; a later ack completes the transfer normally.
